// File: rtl/bus_arbiter.sv
// Bus arbiter sharing the memory bus between the CPU pipeline and one external master.
// Hand-offs pass through a no-grant turnaround gap; hold time and device starvation are bounded.
module bus_arbiter #(
  parameter int TURNAROUND   = 1,
  parameter int MAX_HOLD     = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_bus_request,
  input  logic       cpu_break,
  input  logic       dev_req,
  output logic       cpu_grant,
  output logic       dev_grant,
  output logic       pipeline_stall,
  output logic       preempt,
  output logic [1:0] owner
);

  // Request/grant: a requester holds its request level until done; a grant is only
  // valid while the matching state is held, and turnaround states grant nobody.
  typedef enum logic [1:0] {
    S_CPU         = 2'd0,
    S_TURN_TO_DEV = 2'd1,
    S_DEV         = 2'd2,
    S_TURN_TO_CPU = 2'd3
  } state_t;

  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0] WAIT_LAST = 8'(STARVE_LIMIT - 1);

  state_t     r_state;
  logic [3:0] r_turn_cnt;
  logic [7:0] r_hold_cnt;
  logic [7:0] r_wait_cnt;
  logic       r_preempt;
  logic       r_cpu_grant;
  logic       r_dev_grant;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_CPU;
      r_turn_cnt  <= 4'd0;
      r_hold_cnt  <= 8'd0;
      r_wait_cnt  <= 8'd0;
      r_preempt   <= 1'b0;
      r_cpu_grant <= 1'b1;
      r_dev_grant <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        S_CPU: begin
          // An idle CPU yields at once; a busy CPU yields once the device has waited long enough.
          if (dev_req && (!cpu_bus_request || r_wait_cnt == WAIT_LAST)) begin
            r_state     <= S_TURN_TO_DEV;
            r_cpu_grant <= 1'b0;
            r_wait_cnt  <= 8'd0;
            r_turn_cnt  <= 4'd0;
          end else if (dev_req) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end else begin
            r_wait_cnt <= 8'd0;
          end
        end
        S_TURN_TO_DEV: begin
          if (!dev_req) begin
            r_state    <= S_TURN_TO_CPU;
            r_turn_cnt <= 4'd0;
          end else if (r_turn_cnt == TURN_LAST) begin
            r_state     <= S_DEV;
            r_dev_grant <= 1'b1;
            r_turn_cnt  <= 4'd0;
            r_hold_cnt  <= 8'd0;
          end else begin
            r_turn_cnt <= r_turn_cnt + 4'd1;
          end
        end
        S_DEV: begin
          // Voluntary release is checked first so a simultaneous drop never reports a preempt.
          if (!dev_req) begin
            r_state     <= S_TURN_TO_CPU;
            r_dev_grant <= 1'b0;
            r_hold_cnt  <= 8'd0;
            r_turn_cnt  <= 4'd0;
          end else if (r_hold_cnt == HOLD_LAST && cpu_bus_request && !cpu_break) begin
            r_state     <= S_TURN_TO_CPU;
            r_dev_grant <= 1'b0;
            r_preempt   <= 1'b1;
            r_hold_cnt  <= 8'd0;
            r_turn_cnt  <= 4'd0;
          end else if (r_hold_cnt != HOLD_LAST) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        S_TURN_TO_CPU: begin
          if (r_turn_cnt == TURN_LAST) begin
            r_state     <= S_CPU;
            r_cpu_grant <= 1'b1;
            r_turn_cnt  <= 4'd0;
            r_wait_cnt  <= 8'd0;
          end else begin
            r_turn_cnt <= r_turn_cnt + 4'd1;
          end
        end
        default: begin
          r_state     <= S_CPU;
          r_cpu_grant <= 1'b1;
          r_dev_grant <= 1'b0;
          r_turn_cnt  <= 4'd0;
          r_hold_cnt  <= 8'd0;
          r_wait_cnt  <= 8'd0;
        end
      endcase
    end
  end

  assign cpu_grant      = r_cpu_grant;
  assign dev_grant      = r_dev_grant;
  assign preempt        = r_preempt;
  assign owner          = r_state;
  assign pipeline_stall = cpu_bus_request && !r_cpu_grant;

endmodule
